// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared defaults and types for the fetch-stage program counter
//
// Purpose: default width, reset value and increment step for program_counter,
//          plus the pc_t address type at the default width.
// Ports:   none (package).
// Options: PC_WRAP_FLAG_EN (consumed by program_counter, not by this package).

package pc_pkg;

  localparam int PC_WIDTH_DEFAULT  = 12;
  localparam int RESET_VAL_DEFAULT = 0;
  localparam int INC_STEP_DEFAULT  = 1;

  typedef logic [PC_WIDTH_DEFAULT-1:0] pc_t;

endpackage : pc_pkg

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - next-PC priority select (load / increment / hold)
//
// Purpose: combinational next-state for the program counter register.
// Ports:
//   pc_i     current PC
//   load_i   load enable (highest priority)
//   inc_i    increment enable
//   val_i    absolute load value
//   next_o   next PC value
//   carry_o  1 when an increment is selected and it carries out of PC_WIDTH bits

module pc_next_mux
  import pc_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEFAULT,
  parameter int INC_STEP = INC_STEP_DEFAULT
) (
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic                load_i,
  input  logic                inc_i,
  input  logic [PC_WIDTH-1:0] val_i,
  output logic [PC_WIDTH-1:0] next_o,
  output logic                carry_o
);

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(INC_STEP);

  // One extra bit holds the carry out of the modulo-2^PC_WIDTH add.
  logic [PC_WIDTH:0] sum;
  assign sum = {1'b0, pc_i} + {1'b0, STEP};

  // if/else (rather than a ternary) so an unknown enable falls through to hold.
  always_comb begin
    next_o  = pc_i;
    carry_o = 1'b0;
    if (load_i == 1'b1) begin
      next_o = val_i;
    end else if (inc_i == 1'b1) begin
      next_o  = sum[PC_WIDTH-1:0];
      carry_o = sum[PC_WIDTH];
    end
  end

endmodule : pc_next_mux

// File: rtl/program_counter.sv
// rtl/program_counter.sv - 12-bit fetch-stage program counter register
//
// Purpose: holds the instruction address; each edge loads, increments or holds.
// Ports:
//   i_clk     system clock, rising edge
//   i_rst     asynchronous active-low reset, forces RESET_VAL
//   i_loadPC  load enable, o_PC <= i_PCVal (wins over i_incPC)
//   i_incPC   increment enable, o_PC <= o_PC + INC_STEP
//   i_PCVal   absolute load value
//   o_PC      current PC, straight from the register
//   o_wrap    (PC_WRAP_FLAG_EN only) one-cycle pulse after an increment that wrapped
// Options: PC_WRAP_FLAG_EN adds o_wrap; without it wrap-around is silent.

module program_counter
  import pc_pkg::*;
#(
  parameter int PC_WIDTH  = PC_WIDTH_DEFAULT,
  parameter int RESET_VAL = RESET_VAL_DEFAULT,
  parameter int INC_STEP  = INC_STEP_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_loadPC,
  input  logic                i_incPC,
  input  logic [PC_WIDTH-1:0] i_PCVal,
`ifdef PC_WRAP_FLAG_EN
  output logic                o_wrap,
`endif
  output logic [PC_WIDTH-1:0] o_PC
);

  localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_VAL);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic                carry;

  pc_next_mux #(
    .PC_WIDTH (PC_WIDTH),
    .INC_STEP (INC_STEP)
  ) u_next (
    .pc_i    (pc_q),
    .load_i  (i_loadPC),
    .inc_i   (i_incPC),
    .val_i   (i_PCVal),
    .next_o  (pc_d),
    .carry_o (carry)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pc_q <= RST_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign o_PC = pc_q;

`ifdef PC_WRAP_FLAG_EN
  // carry is only raised on a selected increment, so loads never set the flag.
  logic wrap_q;
  logic wrap_d;
  assign wrap_d = carry;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign o_wrap = wrap_q;
`else
  logic unused_carry;
  assign unused_carry = carry;
`endif

endmodule : program_counter

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - directed self-checking bench for program_counter

module tb_program_counter;
  import pc_pkg::*;

  logic i_clk;
  logic i_rst;
  logic i_loadPC;
  logic i_incPC;
  pc_t  i_PCVal;
  pc_t  o_PC;
`ifdef PC_WRAP_FLAG_EN
  logic o_wrap;
`endif

  int checks;
  int errors;

  program_counter dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_loadPC (i_loadPC),
    .i_incPC  (i_incPC),
    .i_PCVal  (i_PCVal),
`ifdef PC_WRAP_FLAG_EN
    .o_wrap   (o_wrap),
`endif
    .o_PC     (o_PC)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic inc, input int val);
    i_loadPC = ld;
    i_incPC  = inc;
    i_PCVal  = pc_t'(val);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    i_rst  = 1'b1;
    drive(1'b0, 1'b0, 0);

    // Async reset before any clock edge.
    #1 i_rst = 1'b0;
    #1;
    check_eq("reset_async", int'(o_PC), 0);
`ifdef PC_WRAP_FLAG_EN
    check_eq("reset_wrap", int'(o_wrap), 0);
`endif

    // Reset holds even with increment requested.
    drive(1'b0, 1'b1, 0);
    step();
    check_eq("reset_hold_inc0", int'(o_PC), 0);
    step();
    check_eq("reset_hold_inc1", int'(o_PC), 0);

    // Release and increment 4 edges: 1,2,3,4.
    i_rst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check_eq($sformatf("inc_%0d", i), int'(o_PC), i);
    end

    // Load 261 and keep loading.
    drive(1'b1, 1'b0, 261);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("load261_%0d", i), int'(o_PC), 261);
    end

    // Hold 5 edges.
    drive(1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq($sformatf("hold_%0d", i), int'(o_PC), 261);
    end

    // Collision: PC=7, load=inc=1, val=100 -> 100.
    drive(1'b1, 1'b0, 7);
    step();
    check_eq("load7", int'(o_PC), 7);
    drive(1'b1, 1'b1, 100);
    step();
    check_eq("collision", int'(o_PC), 100);

    // Continuous load tracks i_PCVal with one cycle of delay.
    drive(1'b1, 1'b0, 10);
    step();
    check_eq("track10", int'(o_PC), 10);
    drive(1'b1, 1'b0, 20);
    step();
    check_eq("track20", int'(o_PC), 20);

    // Increment to top without wrapping, then wrap.
    drive(1'b1, 1'b0, 4094);
    step();
    check_eq("load4094", int'(o_PC), 4094);
    drive(1'b0, 1'b1, 0);
    step();
    check_eq("inc4095", int'(o_PC), 4095);
`ifdef PC_WRAP_FLAG_EN
    check_eq("no_wrap_4095", int'(o_wrap), 0);
`endif
    drive(1'b0, 1'b0, 0);
    step();
    check_eq("hold4095", int'(o_PC), 4095);
    drive(1'b1, 1'b0, 4095);
    step();
    check_eq("load4095", int'(o_PC), 4095);
`ifdef PC_WRAP_FLAG_EN
    check_eq("load_no_wrap", int'(o_wrap), 0);
`endif
    drive(1'b0, 1'b1, 0);
    step();
    check_eq("wrap_pc", int'(o_PC), 0);
`ifdef PC_WRAP_FLAG_EN
    check_eq("wrap_flag", int'(o_wrap), 1);
`endif
    drive(1'b0, 1'b0, 0);
    step();
    check_eq("after_wrap_pc", int'(o_PC), 0);
`ifdef PC_WRAP_FLAG_EN
    check_eq("wrap_flag_clear", int'(o_wrap), 0);
`endif

    // Async reset mid-run at PC=50.
    drive(1'b1, 1'b0, 50);
    step();
    check_eq("load50", int'(o_PC), 50);
    drive(1'b0, 1'b1, 0);
    #2 i_rst = 1'b0;
    #1;
    check_eq("midrun_reset", int'(o_PC), 0);
    step();
    check_eq("midrun_hold0", int'(o_PC), 0);
    step();
    check_eq("midrun_hold1", int'(o_PC), 0);

    // First edge after release takes effect directly.
    i_rst = 1'b1;
    step();
    check_eq("release_inc", int'(o_PC), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_program_counter
